// File: rtl/ysyx_22050550_csrclint_pkg.sv
// ysyx_22050550_csrclint_pkg: shared CSR enable indices, reset constants, CLINT offsets and byte-merge helper
package ysyx_22050550_csrclint_pkg;
  localparam int CSR_MEPC = 0;
  localparam int CSR_MCAUSE = 1;
  localparam int CSR_MTVEC = 2;
  localparam int CSR_MSTATUS = 3;
  localparam int CSR_MIE = 4;
  localparam int CSR_MIP = 5;
  localparam int MIP_MTIP = 7;
  localparam logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF = 16'hBFF8;
  function automatic logic [63:0] byte_merge(input logic [63:0] old, input logic [63:0] din, input logic [7:0] strb);
    byte_merge = old;
    for (int i = 0; i < 8; i++) if (strb[i]) byte_merge[8*i+:8] = din[8*i+:8];
  endfunction
endpackage

// File: rtl/ysyx_22050550_Reg.sv
// ysyx_22050550_Reg: W-bit flop with sync active-high reset to RST and load enable (clock, reset, i_wen, i_d -> o_q)
module ysyx_22050550_Reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_wen,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clock)
    if (reset) o_q <= RST;
    else if (i_wen) o_q <= i_d;
endmodule

// File: rtl/ysyx_22050550_csrclint_ClintTimer.sv
// ysyx_22050550_ClintTimer: prescaler, mtime/mtimecmp with byte-strobe bus writes, read mux and compare rising-edge set pulse (i_* bus request -> o_set, o_rdata)
module ysyx_22050550_ClintTimer
  import ysyx_22050550_csrclint_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter logic [63:0] CLINT_BASE = 64'h0200_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        i_wen,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wstrb,
  output logic        o_set,
  output logic [63:0] o_rdata
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_pre, w_pre_d;
  logic [63:0] r_time, r_tcmp, w_time_d, w_tcmp_d;
  logic w_win, w_sel_cmp, w_sel_time, w_tick, w_cmp, r_cmp_q;
  always_comb begin
    w_win = i_valid && i_addr[63:16] == CLINT_BASE[63:16];
    w_sel_cmp = w_win && i_addr[15:0] == CLINT_MTIMECMP_OFF;
    w_sel_time = w_win && i_addr[15:0] == CLINT_MTIME_OFF;
    w_tick = r_pre == PW'(PRESCALE - 1);
    w_pre_d = w_tick ? '0 : r_pre + PW'(1);
    w_time_d = (w_sel_time && i_wen) ? byte_merge(r_time, i_wdata, i_wstrb) : r_time + {63'b0, w_tick};
    w_tcmp_d = byte_merge(r_tcmp, i_wdata, i_wstrb);
    w_cmp = r_time >= r_tcmp;
    o_set = w_cmp && !r_cmp_q;
    o_rdata = w_sel_cmp ? r_tcmp : w_sel_time ? r_time : '0;
  end
  ysyx_22050550_Reg #(.W(PW)) u_pre (.clock, .reset, .i_wen(1'b1), .i_d(w_pre_d), .o_q(r_pre));
  ysyx_22050550_Reg #(.W(64)) u_time (.clock, .reset, .i_wen(1'b1), .i_d(w_time_d), .o_q(r_time));
  ysyx_22050550_Reg #(.W(64)) u_tcmp (.clock, .reset, .i_wen(w_sel_cmp && i_wen), .i_d(w_tcmp_d), .o_q(r_tcmp));
  ysyx_22050550_Reg #(.W(1)) u_cmpq (.clock, .reset, .i_wen(1'b1), .i_d(w_cmp), .o_q(r_cmp_q));
endmodule

// File: rtl/ysyx_22050550_csrclint.sv
// ysyx_22050550_csrclint: machine CSR file (wb* + wbcsren -> mepc..mip), retired PC, CLINT timer on dev_req/dev_resp bus with clintinterrupt pulse
module ysyx_22050550_csrclint
  import ysyx_22050550_csrclint_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter logic [63:0] CLINT_BASE = 64'h0200_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] wbmepc,
  input  logic [63:0] wbmcause,
  input  logic [63:0] wbmtvec,
  input  logic [63:0] wbmstatus,
  input  logic [63:0] wbmie,
  input  logic [63:0] wbmip,
  input  logic [7:0]  wbcsren,
  input  logic        retire_valid,
  input  logic [63:0] retire_pc,
  output logic [63:0] mepc,
  output logic [63:0] mcause,
  output logic [63:0] mtvec,
  output logic [63:0] mstatus,
  output logic [63:0] mie,
  output logic [63:0] mip,
  output logic [63:0] regfilepc,
  output logic        clintinterrupt,
  input  logic        dev_req_valid,
  output logic        dev_req_ready,
  input  logic        dev_req_wen,
  input  logic [63:0] dev_req_addr,
  input  logic [63:0] dev_req_wdata,
  input  logic [7:0]  dev_req_wstrb,
  output logic        dev_resp_valid,
  output logic [63:0] dev_resp_rdata
);
  logic [63:0] w_wb [5];
  logic [63:0] r_csr [5];
  logic [63:0] w_mip_d, w_rdata;
  logic w_set, w_unused;
  assign w_wb = '{wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie};
  assign w_unused = ^wbcsren[7:6];
  for (genvar i = 0; i < 5; i++) begin : g_csr
    ysyx_22050550_Reg #(.W(64), .RST(i == CSR_MSTATUS ? MSTATUS_RST : 64'h0)) u_r (
      .clock, .reset, .i_wen(wbcsren[i]), .i_d(w_wb[i]), .o_q(r_csr[i]));
  end
  assign mepc = r_csr[CSR_MEPC];
  assign mcause = r_csr[CSR_MCAUSE];
  assign mtvec = r_csr[CSR_MTVEC];
  assign mstatus = r_csr[CSR_MSTATUS];
  assign mie = r_csr[CSR_MIE];
  assign dev_req_ready = 1'b1;
  // a timer set event wins over a same-cycle write-back for MTIP only
  always_comb begin
    w_mip_d = wbcsren[CSR_MIP] ? wbmip : mip;
    w_mip_d[MIP_MTIP] = w_mip_d[MIP_MTIP] | w_set;
  end
  ysyx_22050550_Reg #(.W(64)) u_mip (.clock, .reset, .i_wen(1'b1), .i_d(w_mip_d), .o_q(mip));
  ysyx_22050550_Reg #(.W(64)) u_pc (.clock, .reset, .i_wen(retire_valid), .i_d(retire_pc), .o_q(regfilepc));
  ysyx_22050550_Reg #(.W(1)) u_irq (.clock, .reset, .i_wen(1'b1), .i_d(w_set), .o_q(clintinterrupt));
  ysyx_22050550_Reg #(.W(1)) u_rv (.clock, .reset, .i_wen(1'b1), .i_d(dev_req_valid), .o_q(dev_resp_valid));
  ysyx_22050550_Reg #(.W(64)) u_rd (.clock, .reset, .i_wen(1'b1), .i_d(w_rdata), .o_q(dev_resp_rdata));
  ysyx_22050550_ClintTimer #(.PRESCALE(PRESCALE), .CLINT_BASE(CLINT_BASE)) u_timer (
    .clock, .reset,
    .i_valid(dev_req_valid), .i_wen(dev_req_wen), .i_addr(dev_req_addr),
    .i_wdata(dev_req_wdata), .i_wstrb(dev_req_wstrb),
    .o_set(w_set), .o_rdata(w_rdata));
endmodule

// File: tb/tb_ysyx_22050550_csrclint.sv
// tb_ysyx_22050550_csrclint: randomized + directed scoreboard bench against a cycle-level reference model
module tb_ysyx_22050550_csrclint;
  localparam int PRESCALE = 1;
  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] MST = 64'h0000_000a_0000_1800;
  localparam logic [63:0] A_CMP = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  logic clock = 0, reset = 1;
  logic [63:0] wbmepc = 0, wbmcause = 0, wbmtvec = 0, wbmstatus = 0, wbmie = 0, wbmip = 0;
  logic [7:0] wbcsren = 0;
  logic retire_valid = 0;
  logic [63:0] retire_pc = 0;
  logic [63:0] mepc, mcause, mtvec, mstatus, mie, mip, regfilepc;
  logic clintinterrupt, dev_req_ready, dev_resp_valid;
  logic dev_req_valid = 0, dev_req_wen = 0;
  logic [63:0] dev_req_addr = 0, dev_req_wdata = 0;
  logic [7:0] dev_req_wstrb = 0;
  logic [63:0] dev_resp_rdata;
  int n_chk = 0, n_fail = 0;
  logic mon_en = 0;
  logic [63:0] m_csr [6];
  logic [63:0] m_pc, m_time, m_cmp;
  logic m_prev, m_int;
  int m_div;
  logic [63:0] exp_q [$];

  ysyx_22050550_csrclint #(.PRESCALE(PRESCALE), .CLINT_BASE(BASE)) dut (
    .clock(clock), .reset(reset),
    .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec), .wbmstatus(wbmstatus),
    .wbmie(wbmie), .wbmip(wbmip), .wbcsren(wbcsren),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .mepc(mepc), .mcause(mcause), .mtvec(mtvec), .mstatus(mstatus), .mie(mie), .mip(mip),
    .regfilepc(regfilepc), .clintinterrupt(clintinterrupt),
    .dev_req_valid(dev_req_valid), .dev_req_ready(dev_req_ready), .dev_req_wen(dev_req_wen),
    .dev_req_addr(dev_req_addr), .dev_req_wdata(dev_req_wdata), .dev_req_wstrb(dev_req_wstrb),
    .dev_resp_valid(dev_resp_valid), .dev_resp_rdata(dev_resp_rdata));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [63:0] wb [6];
    logic c, set, tk;
    wb = '{wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip};
    if (reset) begin
      m_csr = '{64'h0, 64'h0, 64'h0, MST, 64'h0, 64'h0};
      m_pc = 0; m_time = 0; m_cmp = 0; m_prev = 0; m_int = 0; m_div = 0;
      exp_q.delete();
      return;
    end
    c = m_time >= m_cmp;
    set = c && !m_prev;
    m_prev = c;
    m_int = set;
    if (dev_req_valid) exp_q.push_back(dev_req_addr == A_CMP ? m_cmp : dev_req_addr == A_TIME ? m_time : 64'h0);
    for (int i = 0; i < 6; i++) if (wbcsren[i]) m_csr[i] = wb[i];
    if (set) m_csr[5][7] = 1'b1;
    if (retire_valid) m_pc = retire_pc;
    m_div++;
    tk = m_div == PRESCALE;
    if (tk) m_div = 0;
    if (dev_req_valid && dev_req_wen && dev_req_addr == A_TIME) begin
      for (int b = 0; b < 8; b++) if (dev_req_wstrb[b]) m_time[8*b+:8] = dev_req_wdata[8*b+:8];
    end else if (tk) m_time = m_time + 1;
    if (dev_req_valid && dev_req_wen && dev_req_addr == A_CMP)
      for (int b = 0; b < 8; b++) if (dev_req_wstrb[b]) m_cmp[8*b+:8] = dev_req_wdata[8*b+:8];
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      chk("mepc", mepc, m_csr[0]);
      chk("mcause", mcause, m_csr[1]);
      chk("mtvec", mtvec, m_csr[2]);
      chk("mstatus", mstatus, m_csr[3]);
      chk("mie", mie, m_csr[4]);
      chk("mip", mip, m_csr[5]);
      chk("regfilepc", regfilepc, m_pc);
      chk("clintinterrupt", clintinterrupt, m_int);
      chk("req_ready", dev_req_ready, 1);
      chk("resp_valid", dev_resp_valid, exp_q.size() > 0);
      if (dev_resp_valid && exp_q.size() > 0) chk("resp_rdata", dev_resp_rdata, exp_q.pop_front());
      else exp_q.delete();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic bus(input logic wen, input logic [63:0] addr, input logic [63:0] d, input logic [7:0] s);
    dev_req_valid = 1; dev_req_wen = wen; dev_req_addr = addr; dev_req_wdata = d; dev_req_wstrb = s;
    step();
    dev_req_valid = 0; dev_req_wen = 0;
  endtask

  initial begin
    int k;
    logic got;
    logic [1:0] sel;
    repeat (3) step();
    chk("rst_mstatus", mstatus, 64'ha00001800);
    chk("rst_mepc", mepc, 0);
    chk("rst_mip", mip, 0);
    chk("rst_irq", clintinterrupt, 0);
    chk("rst_resp_valid", dev_resp_valid, 0);
    chk("rst_resp_rdata", dev_resp_rdata, 0);
    chk("rst_ready", dev_req_ready, 1);
    mon_en = 1;
    reset = 0;
    step();
    chk("post_rst_pulse", clintinterrupt, 1);
    chk("post_rst_mtip", mip, 64'h80);
    wbcsren = 8'h20; wbmip = 0;
    step();
    wbcsren = 0;
    chk("mip_cleared", mip, 0);
    wbcsren = 8'h05; wbmepc = 64'h8000_0010; wbmtvec = 64'h8000_0100; wbmcause = 64'hdead;
    wbmstatus = 64'h1; wbmie = 64'h2; wbmip = 64'h3;
    retire_valid = 1; retire_pc = 64'h8000_0004;
    step();
    wbcsren = 0; retire_valid = 0;
    chk("wr_mepc", mepc, 64'h8000_0010);
    chk("wr_mtvec", mtvec, 64'h8000_0100);
    chk("keep_mcause", mcause, 0);
    chk("keep_mstatus", mstatus, 64'ha00001800);
    chk("keep_mie", mie, 0);
    chk("keep_mip", mip, 0);
    chk("retire_pc", regfilepc, 64'h8000_0004);
    bus(1, A_CMP, 64'd20, 8'hFF);
    bus(0, A_CMP, 0, 0);
    chk("cmp_readback", dev_resp_rdata, 64'd20);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (clintinterrupt) got = 1;
      else chk("mtip_low_pre", mip[7], 0);
    end
    chk("pulse20_seen", got, 1);
    chk("pulse20_mtip", mip[7], 1);
    bus(0, A_TIME, 0, 0);
    chk("mtime_at_pulse", dev_resp_rdata, 64'd21);
    chk("pulse_one_cycle", clintinterrupt, 0);
    wbcsren = 8'h20; wbmip = 0;
    step();
    wbcsren = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_repulse", clintinterrupt, 0);
    end
    bus(1, A_CMP, m_time + 5, 8'hFF);
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      step();
      if (clintinterrupt) k = i;
    end
    chk("pulse_after_5", k, 5);
    bus(1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'h0F);
    bus(0, A_TIME, 0, 0);
    chk("mtime_strb", dev_resp_rdata, 64'h0000_0000_FFFF_FFFE);
    bus(1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    bus(0, A_TIME, 0, 0);
    chk("mtime_ones", dev_resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    bus(0, A_TIME, 0, 0);
    chk("mtime_wrap", dev_resp_rdata, 64'h0);
    bus(1, BASE + 64'h10, 64'h55, 8'hFF);
    bus(0, BASE + 64'h10, 0, 0);
    chk("other_reads0", dev_resp_rdata, 64'h0);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (m_time >= m_cmp && !m_prev) got = 1;
      else step();
    end
    chk("set_event_found", got, 1);
    wbcsren = 8'h20; wbmip = 64'h8;
    step();
    wbcsren = 0;
    chk("set_vs_wb_mip", mip, 64'h88);
    chk("set_vs_wb_irq", clintinterrupt, 1);
    for (int i = 0; i < 600; i++) begin
      wbcsren = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      wbmepc = {$urandom, $urandom}; wbmcause = {$urandom, $urandom}; wbmtvec = {$urandom, $urandom};
      wbmstatus = {$urandom, $urandom}; wbmie = {$urandom, $urandom}; wbmip = {$urandom, $urandom};
      retire_valid = 1'($urandom); retire_pc = {$urandom, $urandom};
      dev_req_valid = 1'($urandom); dev_req_wen = 1'($urandom);
      sel = 2'($urandom);
      dev_req_addr = sel == 0 ? A_CMP : sel == 1 ? A_TIME : sel == 2 ? BASE + 64'h8 : A_TIME + 64'h1_0000;
      dev_req_wdata = sel == 0 ? m_time + 64'($urandom_range(0, 20)) : 64'($urandom_range(0, 200));
      dev_req_wstrb = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
      step();
    end
    wbcsren = 0; retire_valid = 0;
    dev_req_valid = 1; dev_req_wen = 0; dev_req_addr = A_TIME;
    reset = 1;
    step();
    chk("rst_drop_resp", dev_resp_valid, 0);
    chk("rst_drop_rdata", dev_resp_rdata, 0);
    dev_req_valid = 0; reset = 0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22050550_csrclint.md
# ysyx_22050550_csrclint

Machine-mode CSR storage and CLINT timer: the write-back unit's counterpart. The block holds mepc/mcause/mtvec/mstatus/mie/mip and the last-retired PC. It applies the per-CSR write enables and data produced at write-back, and presents the current values back to write-back combinationally. It also owns mtime/mtimecmp, which are memory-mapped on the LSU's device bus, and raises the timer interrupt that write-back consumes.

## Interface
- `PRESCALE`, 1: core cycles per mtime tick (≥1).
- `CLINT_BASE`, 64'h0200_0000: CLINT window base address (64 KiB window).
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `wbmepc`, `wbmcause`, `wbmtvec`, `wbmstatus`, `wbmie`, `wbmip` in 64 each: CSR write data from write-back.
- `wbcsren` in 8: write enables. Bit 0 mepc, 1 mcause, 2 mtvec, 3 mstatus, 4 mie, 5 mip. Bits 7:6 ignored.
- `retire_valid` in 1, `retire_pc` in 64: retiring instruction.
- `mepc`, `mcause`, `mtvec`, `mstatus`, `mie`, `mip` out 64 each: current CSR values.
- `regfilepc` out 64: PC of the last retired instruction.
- `clintinterrupt` out 1: timer interrupt pulse.
- `dev_req_valid` in 1, `dev_req_ready` out 1, `dev_req_wen` in 1, `dev_req_addr` in 64, `dev_req_wdata` in 64, `dev_req_wstrb` in 8: CLINT access request.
- `dev_resp_valid` out 1, `dev_resp_rdata` out 64: CLINT access response.

## Operation
- CSR registers: on each clock, every CSR whose enable bit is set loads its wb* input. No merging; write-back supplies full 64-bit values.
- Exception: mip bit 7 (MTIP) is set by the timer. When a timer set event and `wbcsren[5]` occur in the same cycle, the set wins for bit 7 and bits 63:8 and 6:0 take `wbmip`.
- mstatus resets to 64'h0000_000a_0000_1800. All other CSRs, `regfilepc`, mtime and mtimecmp reset to 0. mtimecmp reset value makes the compare true immediately after reset; the resulting pulse is masked by `mstatus[3]` = 0 at write-back.
- `regfilepc` loads `retire_pc` when `retire_valid` is set, otherwise holds.
- Timer prescaler counts 0..PRESCALE-1. On wrap, mtime increments by 1, modulo 2^64 (wraps to 0).
- Compare flag `cmp` = (mtime ≥ mtimecmp), unsigned 64-bit, registered each cycle as `cmp_q`.
- Set event: `cmp` && !`cmp_q` (rising edge). On a set event, mip[7] is set and `clintinterrupt` pulses high for exactly one cycle, aligned with mip[7] becoming visible.
- Write-back clears mip[7] through `wbmip`/`wbcsren`. A level-high compare does not re-set MTIP; only a new rising edge does, for example after software raises mtimecmp.
- Device bus register map:
  - `CLINT_BASE`+0x4000: mtimecmp.
  - `CLINT_BASE`+0xBFF8: mtime.
  - Other in-window addresses read 0, writes are dropped.
  - `dev_req_ready` is tied high.
- Writes apply per byte of `wstrb`. A write to mtime in the same cycle as a prescaler tick takes the written value; no increment that cycle.
- Reads return the value before any same-cycle update.

## Timing
- CSR write at edge N: value visible on the output after edge N (combinational from register).
- Device request accepted at edge N: `dev_resp_valid` = 1 for exactly one cycle after edge N, with `dev_resp_rdata` valid during that cycle. Back-to-back requests are allowed every cycle.
- mtimecmp/mtime write at edge N: `cmp` re-evaluated after edge N; the earliest resulting `clintinterrupt` is the cycle after edge N+1.
- Reset values: `clintinterrupt`, `dev_resp_valid` and `dev_resp_rdata` = 0; `dev_req_ready` = 1 (tied).
- Reset asserted mid-access drops any pending response.

## Structure
- Shared define file:
  - CSR enable bit indices.
  - Reset mstatus constant.
  - CLINT offsets 0x4000 and 0xBFF8.
- Sub-module `ysyx_22050550_ClintTimer`: prescaler, mtime, mtimecmp, byte-strobe writes, read mux, edge detect. Outputs a set-event pulse and read data.
- Single-bit and 64-bit flops use the existing `ysyx_22050550_Reg`.

## Test plan
- Reset, then read the outputs: mstatus = 64'ha00001800, the other CSRs = 0.
- `wbcsren` = 8'h05, `wbmepc` = 0x8000_0010, `wbmtvec` = 0x8000_0100: next cycle mepc and mtvec are updated; mcause/mstatus/mie/mip are unchanged.
- PRESCALE = 1. Write mtimecmp = 20 (wstrb FF), read back → `dev_resp_rdata` = 20 one cycle later. While mtime is below 20: `clintinterrupt` = 0, mip[7] = 0. When mtime reaches 20: `clintinterrupt` pulses for one cycle and mip[7] = 1.
- With mip[7] = 1 the write-back clears it (`wbcsren[5]`, `wbmip` = 0): no further pulse while mtime ≥ mtimecmp. Then write mtimecmp = mtime+5: a pulse occurs 5 ticks later.
- Write mtime = 64'hFFFF_FFFF_FFFF_FFFE with wstrb 8'h0F on a tick cycle: only the low 4 bytes are written and there is no increment. Then set mtime all-ones: the next tick wraps to 0.
- Simultaneous set event and `wbcsren[5]` with `wbmip` = 0x8: mip = 0x88 next cycle.
